// File: rtl/imm_extend_stage.sv
// imm_extend_stage
//   Registered immediate-extension stage between decode and execute.
//   Forms a sign- or zero-extended immediate of DATA_W bits from a 16-bit
//   instruction word and a 3-bit mode. Mode 7 is an EXTEND prefix: it is held
//   in r_pfx and widens the next extendable instruction to a full 16-bit
//   immediate. Single-entry output register with valid/ready flow control.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous flush: drops the held output, any pending prefix
//                and any word offered in the same cycle
//   in_valid/in_ready/in_instr/in_mode   input word handshake
//   out_valid/out_ready/out_imm/out_ext  output immediate handshake
//   err          one-cycle pulse after a malformed prefix sequence
module imm_extend_stage #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  input  logic [2:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_ext,
  output logic              err
);

  typedef enum logic {S_IDLE, S_PFX} state_t;

  state_t              r_state;
  logic [10:0]         r_pfx;
  logic                r_valid;
  logic [DATA_W-1:0]   r_imm;
  logic                r_ext;
  logic                r_err;

  logic                w_accept;
  logic                w_extendable;
  logic [15:0]         w_imm16;
  logic [DATA_W-1:0]   w_norm;
  logic [DATA_W-1:0]   w_wide;
  logic                w_unused;

  // Bits [15:11] never feed an immediate field.
  assign w_unused = ^in_instr[15:11];

  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready && !flush;

  assign out_valid = r_valid;
  assign out_imm   = r_imm;
  assign out_ext   = r_ext;
  assign err       = r_err;

  // Size casts of $signed operands sign-extend; of unsigned operands zero-fill.
  always_comb begin
    w_norm = '0;
    case (in_mode)
      3'd0:    w_norm = DATA_W'($signed(in_instr[7:0]));
      3'd1:    w_norm = DATA_W'($signed(in_instr[3:0]));
      3'd2:    w_norm = DATA_W'($signed(in_instr[10:0]));
      3'd3:    w_norm = DATA_W'(in_instr[3:0]);
      3'd4:    w_norm = DATA_W'(in_instr[7:0]);
      3'd5:    w_norm = DATA_W'($signed(in_instr[4:0]));
      3'd6:    w_norm = DATA_W'(in_instr[4:2]);
      default: w_norm = '0;
    endcase
  end

  // Prefix supplies the upper 11 bits, split as [4:0] on top then [10:5].
  assign w_imm16      = {r_pfx[4:0], r_pfx[10:5], in_instr[4:0]};
  assign w_extendable = (in_mode == 3'd0) || (in_mode == 3'd1) ||
                        (in_mode == 3'd3) || (in_mode == 3'd4) ||
                        (in_mode == 3'd5);
  assign w_wide       = ((in_mode == 3'd3) || (in_mode == 3'd4)) ?
                        DATA_W'(w_imm16) : DATA_W'($signed(w_imm16));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pfx   <= '0;
      r_valid <= 1'b0;
      r_imm   <= '0;
      r_ext   <= 1'b0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_valid && out_ready)
        r_valid <= 1'b0;
      if (w_accept) begin
        if (in_mode == 3'd7) begin
          // Prefix after prefix: newest wins, flagged as an error.
          r_pfx   <= in_instr[10:0];
          r_state <= S_PFX;
          if (r_state == S_PFX)
            r_err <= 1'b1;
        end else begin
          r_valid <= 1'b1;
          r_state <= S_IDLE;
          if (r_state == S_PFX && w_extendable) begin
            r_imm <= w_wide;
            r_ext <= 1'b1;
          end else begin
            r_imm <= w_norm;
            r_ext <= 1'b0;
            if (r_state == S_PFX)
              r_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
module tb_imm_extend_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [15:0] in_instr;
  logic [2:0]  in_mode;

  logic        a_rdy, a_vld, a_ext, a_err;
  logic [15:0] a_imm;
  logic        b_rdy, b_vld, b_ext, b_err;
  logic [31:0] b_imm;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_extend_stage #(.DATA_W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(a_rdy), .in_instr(in_instr), .in_mode(in_mode),
    .out_valid(a_vld), .out_ready(out_ready), .out_imm(a_imm),
    .out_ext(a_ext), .err(a_err));

  imm_extend_stage #(.DATA_W(32)) u32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(b_rdy), .in_instr(in_instr), .in_mode(in_mode),
    .out_valid(b_vld), .out_ready(out_ready), .out_imm(b_imm),
    .out_ext(b_ext), .err(b_err));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic [15:0] w, input logic r);
    in_valid = v; in_mode = m; in_instr = w; out_ready = r;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Checks both widths; imm/ext only compared when a valid output is expected.
  task automatic chk_out(input string nm, input logic v, input logic [15:0] e16,
                         input logic [31:0] e32, input logic x, input logic e);
    chk({nm, ".valid16"}, 64'(a_vld), 64'(v));
    chk({nm, ".valid32"}, 64'(b_vld), 64'(v));
    chk({nm, ".err16"},   64'(a_err), 64'(e));
    chk({nm, ".err32"},   64'(b_err), 64'(e));
    if (v) begin
      chk({nm, ".imm16"}, 64'(a_imm), 64'(e16));
      chk({nm, ".imm32"}, 64'(b_imm), 64'(e32));
      chk({nm, ".ext16"}, 64'(a_ext), 64'(x));
      chk({nm, ".ext32"}, 64'(b_ext), 64'(x));
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic longint fld(input logic [15:0] w, input int lo, input int n, input bit sg);
    longint f;
    f = (longint'(w) >> lo) & ((longint'(1) << n) - 1);
    if (sg && f >= (longint'(1) << (n - 1))) f = f - (longint'(1) << n);
    return f;
  endfunction

  function automatic longint norm_val(input logic [2:0] m, input logic [15:0] w);
    case (m)
      3'd0: return fld(w, 0, 8, 1);
      3'd1: return fld(w, 0, 4, 1);
      3'd2: return fld(w, 0, 11, 1);
      3'd3: return fld(w, 0, 4, 0);
      3'd4: return fld(w, 0, 8, 0);
      3'd5: return fld(w, 0, 5, 1);
      3'd6: return fld(w, 2, 3, 0);
      default: return 0;
    endcase
  endfunction

  function automatic longint wide_val(input logic [10:0] p, input logic [2:0] m, input logic [15:0] w);
    longint v;
    v = longint'(p[4:0]) * 2048 + longint'(p[10:5]) * 32 + longint'(w[4:0]);
    if ((m == 3'd0 || m == 3'd1 || m == 3'd5) && v >= 32768) v = v - 65536;
    return v;
  endfunction

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] instr;
    logic [15:0] e16;
    logic [31:0] e32;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        m_vld, m_ext, m_err, m_pend, m_rdy, acc;
    logic [10:0] m_pfx;
    logic [63:0] m_val;

    tbl[0]  = '{3'd0, 16'h0080, 16'hFF80, 32'hFFFFFF80};
    tbl[1]  = '{3'd4, 16'h0080, 16'h0080, 32'h00000080};
    tbl[2]  = '{3'd6, 16'h001C, 16'h0007, 32'h00000007};
    tbl[3]  = '{3'd1, 16'h0008, 16'hFFF8, 32'hFFFFFFF8};
    tbl[4]  = '{3'd2, 16'h0400, 16'hFC00, 32'hFFFFFC00};
    tbl[5]  = '{3'd3, 16'h00FF, 16'h000F, 32'h0000000F};
    tbl[6]  = '{3'd5, 16'h0010, 16'hFFF0, 32'hFFFFFFF0};
    tbl[7]  = '{3'd5, 16'h000F, 16'h000F, 32'h0000000F};
    tbl[8]  = '{3'd0, 16'h007F, 16'h007F, 32'h0000007F};
    tbl[9]  = '{3'd2, 16'h03FF, 16'h03FF, 32'h000003FF};
    tbl[10] = '{3'd4, 16'hFFFF, 16'h00FF, 32'h000000FF};
    tbl[11] = '{3'd1, 16'h0007, 16'h0007, 32'h00000007};

    rst_n = 1'b0; flush = 1'b0;
    drive(0, 3'd0, 16'h0, 1);
    #12;
    chk_out("reset", 0, 16'h0, 32'h0, 0, 0);
    chk("reset.imm16", 64'(a_imm), 64'h0);
    chk("reset.imm32", 64'(b_imm), 64'h0);
    chk("reset.ext32", 64'(b_ext), 64'h0);
    rst_n = 1'b1;
    tick();

    // Basic modes, back-to-back, 1-cycle latency.
    for (int i = 0; i < 12; i++) begin
      drive(1, tbl[i].mode, tbl[i].instr, 1);
      tick();
      chk_out($sformatf("vec%0d", i), 1, tbl[i].e16, tbl[i].e32, 0, 0);
    end
    drive(0, 3'd0, 16'h0, 1); tick();
    chk_out("drain", 0, 16'h0, 32'h0, 0, 0);

    // Sign-extended prefix.
    drive(1, 3'd7, 16'h07FF, 1); tick();
    chk_out("pfxA.hold", 0, 16'h0, 32'h0, 0, 0);
    drive(1, 3'd5, 16'h001F, 1); tick();
    chk_out("pfxA", 1, 16'hFFFF, 32'hFFFFFFFF, 1, 0);
    drive(1, 3'd7, 16'h0010, 1); tick();
    drive(1, 3'd0, 16'h0005, 1); tick();
    chk_out("pfxB", 1, 16'h8005, 32'hFFFF8005, 1, 0);

    // Zero-extended prefix across an idle gap.
    drive(1, 3'd7, 16'h0010, 1); tick();
    drive(0, 3'd0, 16'h0, 1);
    repeat (5) tick();
    chk_out("pfxC.gap", 0, 16'h0, 32'h0, 0, 0);
    drive(1, 3'd3, 16'h0005, 1); tick();
    chk_out("pfxC", 1, 16'h8005, 32'h00008005, 1, 0);

    // Prefix followed by a non-extendable mode.
    drive(1, 3'd7, 16'h0000, 1); tick();
    drive(1, 3'd2, 16'h0400, 1); tick();
    chk_out("errD", 1, 16'hFC00, 32'hFFFFFC00, 0, 1);
    drive(0, 3'd0, 16'h0, 1); tick();
    chk_out("errD.after", 0, 16'h0, 32'h0, 0, 0);

    // Prefix after prefix: second one is used.
    drive(1, 3'd7, 16'h0001, 1); tick();
    drive(1, 3'd7, 16'h07E0, 1); tick();
    chk_out("errE", 0, 16'h0, 32'h0, 0, 1);
    drive(1, 3'd4, 16'h0001, 1); tick();
    chk_out("errE.use", 1, 16'h07E1, 32'h000007E1, 1, 0);
    drive(0, 3'd0, 16'h0, 1); tick();

    // Backpressure then full-rate stream.
    drive(1, 3'd0, 16'h0080, 0); tick();
    chk_out("bp.load", 1, 16'hFF80, 32'hFFFFFF80, 0, 0);
    drive(1, 3'd4, 16'h0055, 0);
    for (int i = 0; i < 3; i++) begin
      chk("bp.in_ready16", 64'(a_rdy), 64'h0);
      chk("bp.in_ready32", 64'(b_rdy), 64'h0);
      tick();
      chk_out("bp.stall", 1, 16'hFF80, 32'hFFFFFF80, 0, 0);
    end
    drive(1, 3'd4, 16'h0055, 1); tick();
    chk_out("bp.s0", 1, 16'h0055, 32'h00000055, 0, 0);
    drive(1, 3'd4, 16'h0066, 1); tick();
    chk_out("bp.s1", 1, 16'h0066, 32'h00000066, 0, 0);
    drive(1, 3'd4, 16'h0077, 1); tick();
    chk_out("bp.s2", 1, 16'h0077, 32'h00000077, 0, 0);
    drive(0, 3'd0, 16'h0, 1); tick();
    chk_out("bp.drain", 0, 16'h0, 32'h0, 0, 0);

    // Flush drops a word offered in the same cycle.
    flush = 1'b1; drive(1, 3'd0, 16'h0001, 1); tick();
    flush = 1'b0;
    chk_out("flushG", 0, 16'h0, 32'h0, 0, 0);

    // Flush while a prefix is pending.
    drive(1, 3'd7, 16'h07FF, 1); tick();
    flush = 1'b1; drive(0, 3'd0, 16'h0, 1); tick();
    flush = 1'b0;
    drive(1, 3'd0, 16'h0005, 1); tick();
    chk_out("flushH", 1, 16'h0005, 32'h00000005, 0, 0);

    // Async reset with a prefix pending and a stale immediate in the register.
    drive(1, 3'd7, 16'h07FF, 1); tick();
    drive(0, 3'd0, 16'h0, 1);
    rst_n = 1'b0; #1;
    chk_out("rst.mid", 0, 16'h0, 32'h0, 0, 0);
    chk("rst.mid.imm16", 64'(a_imm), 64'h0);
    chk("rst.mid.imm32", 64'(b_imm), 64'h0);
    #10 rst_n = 1'b1;
    tick();
    drive(1, 3'd0, 16'h0005, 1); tick();
    chk_out("rst.after", 1, 16'h0005, 32'h00000005, 0, 0);
    drive(0, 3'd0, 16'h0, 1); tick();

    // Randomized phase against the reference model.
    m_vld = 0; m_ext = 0; m_err = 0; m_pend = 0; m_pfx = '0; m_val = '0;
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_mode   = 3'($urandom_range(0, 7));
      in_instr  = 16'($urandom);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      m_rdy = !m_vld || out_ready;
      chk("rnd.in_ready16", 64'(a_rdy), 64'(m_rdy));
      chk("rnd.in_ready32", 64'(b_rdy), 64'(m_rdy));
      acc = in_valid && m_rdy && !flush;
      @(posedge clk);
      if (flush) begin
        m_vld = 0; m_pend = 0; m_err = 0;
      end else begin
        m_err = 0;
        if (m_vld && out_ready) m_vld = 0;
        if (acc) begin
          if (in_mode == 3'd7) begin
            if (m_pend) m_err = 1;
            m_pend = 1;
            m_pfx  = in_instr[10:0];
          end else begin
            m_vld = 1;
            if (m_pend && in_mode != 3'd2 && in_mode != 3'd6) begin
              m_val = 64'(wide_val(m_pfx, in_mode, in_instr));
              m_ext = 1;
            end else begin
              m_val = 64'(norm_val(in_mode, in_instr));
              m_ext = 0;
              if (m_pend) m_err = 1;
            end
            m_pend = 0;
          end
        end
      end
      #1;
      chk_out($sformatf("rnd%0d", c), m_vld, m_val[15:0], m_val[31:0], m_ext, m_err);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
